// File: rtl/pu_pkg.sv
// pu_pkg: opcodes, compare-condition indices and pipeline-stage type shared by the add/compare unit.
package pu_pkg;
   localparam int PU_REG_W_MAX = 64;
   typedef enum logic [2:0] {
      OPC_NONE = 3'd0, OPC_SUB = 3'd1, OPC_ADD = 3'd2, OPC_ICMP = 3'd3,
      OPC_ADDI = 3'd4, OPC_ICMPI = 3'd5, OPC_ADDC = 3'd6, OPC_RSVD = 3'd7
   } pu_op_e;
   localparam logic [3:0] FLAG_INDEX_NEQ = 4'd1;
   localparam logic [3:0] FLAG_INDEX_GTU = 4'd2;
   localparam logic [3:0] FLAG_INDEX_GTS = 4'd3;
   localparam logic [3:0] FLAG_INDEX_GEU = 4'd4;
   localparam logic [3:0] FLAG_INDEX_GES = 4'd5;
   localparam logic [3:0] FLAG_INDEX_LTU = 4'd6;
   localparam logic [3:0] FLAG_INDEX_LTS = 4'd7;
   localparam logic [3:0] FLAG_INDEX_LEU = 4'd8;
   localparam logic [3:0] FLAG_INDEX_LES = 4'd9;
   localparam logic [3:0] FLAG_INDEX_EQ = 4'd10;
   typedef struct packed {
      logic valid;
      pu_op_e op;
      logic [4:0] regd;
      logic [3:0] cmp_op;
      logic [PU_REG_W_MAX-1:0] a;
      logic [PU_REG_W_MAX-1:0] b;
   } pu_stage_t;
   function automatic logic pu_writes_reg(pu_op_e op);
      return op inside {OPC_ADD, OPC_SUB, OPC_ADDI, OPC_ADDC};
   endfunction
endpackage

// File: rtl/pu_add_cmp_pipe_if.sv
// pu_add_cmp_pipe_if: issue, operand-read and writeback signals between control unit and add/compare unit.
interface pu_add_cmp_pipe_if #(
   parameter int REG_W = 64,
   parameter int OPC_W = 6,
   parameter int IMM_W = 16
);
   logic i_valid, i_stall, i_unique_ack, o_unique_ack;
   logic [OPC_W-1:0] i_opcode;
   logic [4:0] i_rega, i_regb, i_regd, o_sela, o_selb, o_write_reg, o_busy_reg;
   logic [IMM_W-1:0] i_imm;
   logic [3:0] i_cmp_op;
   logic [REG_W-1:0] i_ina, i_inb, o_write_data;
   logic o_write_en, o_flag_cmp, o_write_flag, o_flag_cy, o_flag_ov, o_busy;
   modport slave (
      input i_valid, i_stall, i_unique_ack, i_opcode, i_rega, i_regb, i_regd, i_imm, i_cmp_op, i_ina, i_inb,
      output o_unique_ack, o_sela, o_selb, o_write_reg, o_write_data, o_write_en, o_flag_cmp, o_write_flag,
      output o_flag_cy, o_flag_ov, o_busy, o_busy_reg
   );
   modport master (
      output i_valid, i_stall, i_unique_ack, i_opcode, i_rega, i_regb, i_regd, i_imm, i_cmp_op, i_ina, i_inb,
      input o_unique_ack, o_sela, o_selb, o_write_reg, o_write_data, o_write_en, o_flag_cmp, o_write_flag,
      input o_flag_cy, o_flag_ov, o_busy, o_busy_reg
   );
endinterface

// File: rtl/pu_addsub_core.sv
// pu_addsub_core: combinational add/subtract with carry, signed overflow and compare-condition decode.
module pu_addsub_core
   import pu_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   input  logic         cin,
   input  logic [3:0]   cmp_op,
   output logic [W-1:0] sum,
   output logic         c,
   output logic         ov,
   output logic         flag
);
   logic [W-1:0] bx;
   logic eq, ltu, lts;
   always_comb begin
      bx = sub ? ~b : b;
      {c, sum} = {1'b0, a} + {1'b0, bx} + (W+1)'(cin);
      ov = (a[W-1] == bx[W-1]) & (a[W-1] ^ sum[W-1]);
      eq = a == b;
      ltu = !c;
      lts = sum[W-1] ^ ov;
      case (cmp_op)
         FLAG_INDEX_EQ:  flag = eq;
         FLAG_INDEX_NEQ: flag = !eq;
         FLAG_INDEX_GTU: flag = !ltu & !eq;
         FLAG_INDEX_GTS: flag = !lts & !eq;
         FLAG_INDEX_GEU: flag = !ltu;
         FLAG_INDEX_GES: flag = !lts;
         FLAG_INDEX_LTU: flag = ltu;
         FLAG_INDEX_LTS: flag = lts;
         FLAG_INDEX_LEU: flag = ltu | eq;
         FLAG_INDEX_LES: flag = lts | eq;
         default:        flag = 1'b0;
      endcase
   end
endmodule

// File: rtl/pu_add_cmp_pipe.sv
// pu_add_cmp_pipe: pipelined ADD/SUB/ADDI/ADDC/ICMP/ICMPI unit with CY/OV flags and 1- or 2-stage latency.
// Define PU_ADD_CMP_SATURATE_EN to saturate ADD/SUB/ADDI results on signed overflow.
module pu_add_cmp_pipe
   import pu_pkg::*;
#(
   parameter int OPTION_REG_WIDTH    = 64,
   parameter int OPTION_OPCODE_WIDTH = 6,
   parameter int OPTION_IMM_WIDTH    = 16,
   parameter int OPTION_PIPE_STAGES  = 2
) (
   input logic i_clk,
   input logic i_rst,
   pu_add_cmp_pipe_if.slave bus
);
   localparam int W = OPTION_REG_WIDTH;
   localparam int OW = OPTION_OPCODE_WIDTH;
   localparam int IW = OPTION_IMM_WIDTH;
   logic match, uses_imm, ack;
   logic [W-1:0] imm_ext;
   pu_stage_t iss, ex;
   logic s1_busy, s1_wr;
   logic [4:0] s1_regd;
   always_comb begin
      match = bus.i_opcode inside {OW'(OPC_SUB), OW'(OPC_ADD), OW'(OPC_ICMP), OW'(OPC_ADDI), OW'(OPC_ICMPI), OW'(OPC_ADDC)};
      uses_imm = bus.i_opcode inside {OW'(OPC_ADDI), OW'(OPC_ICMPI)};
      ack = bus.i_valid & !bus.i_stall & !bus.i_unique_ack & match;
      imm_ext = {{(W-IW){bus.i_imm[IW-1]}}, bus.i_imm};
      iss = '{valid: ack, op: pu_op_e'(bus.i_opcode[2:0]), regd: bus.i_regd, cmp_op: bus.i_cmp_op,
              a: PU_REG_W_MAX'(bus.i_ina), b: PU_REG_W_MAX'(uses_imm ? imm_ext : bus.i_inb)};
   end
   generate
      if (OPTION_PIPE_STAGES == 2) begin : g_s1
         pu_stage_t s1_q, s1_d;
         always_comb s1_d = bus.i_stall ? s1_q : iss;
         always_ff @(posedge i_clk or posedge i_rst)
            if (i_rst) s1_q <= '0;
            else s1_q <= s1_d;
         assign ex = s1_q;
         assign s1_busy = s1_q.valid;
         assign s1_wr = s1_q.valid & pu_writes_reg(s1_q.op);
         assign s1_regd = s1_q.regd;
      end else begin : g_s0
         assign ex = iss;
         assign s1_busy = 1'b0;
         assign s1_wr = 1'b0;
         assign s1_regd = '0;
      end
   endgenerate
   logic [W-1:0] sum, res, wb_data_q, wb_data_d;
   logic c, ov, cmp_flag, sub, cin, ex_wr, ld;
   logic wb_valid_q, wb_valid_d, wb_wr_q, wb_wr_d, flag_cmp_q, flag_cmp_d, cy_q, cy_d, ov_q, ov_d;
   logic [4:0] wb_reg_q, wb_reg_d;
   // Older flag writers have already committed CY by the time a younger op executes, so cy_q is the forwarded value.
   assign sub = ex.op inside {OPC_SUB, OPC_ICMP, OPC_ICMPI};
   assign cin = sub | (ex.op == OPC_ADDC & cy_q);
   assign ex_wr = pu_writes_reg(ex.op);
   pu_addsub_core #(.W(W)) u_core (
      .a(ex.a[W-1:0]), .b(ex.b[W-1:0]), .sub(sub), .cin(cin), .cmp_op(ex.cmp_op),
      .sum(sum), .c(c), .ov(ov), .flag(cmp_flag)
   );
`ifdef PU_ADD_CMP_SATURATE_EN
   assign res = (ov & (ex.op inside {OPC_ADD, OPC_SUB, OPC_ADDI})) ? {ex.a[W-1], {(W-1){!ex.a[W-1]}}} : sum;
`else
   assign res = sum;
`endif
   always_comb begin
      ld = !bus.i_stall & ex.valid;
      wb_valid_d = bus.i_stall ? wb_valid_q : ex.valid;
      wb_wr_d = ld ? ex_wr : wb_wr_q;
      wb_reg_d = ld ? ex.regd : wb_reg_q;
      wb_data_d = ld ? res : wb_data_q;
      flag_cmp_d = (ld & !ex_wr) ? cmp_flag : flag_cmp_q;
      cy_d = (ld & ex_wr) ? (ex.op == OPC_SUB ? !c : c) : cy_q;
      ov_d = (ld & ex_wr) ? ov : ov_q;
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         wb_valid_q <= 1'b0;
         wb_wr_q <= 1'b0;
         wb_reg_q <= '0;
         wb_data_q <= '0;
         flag_cmp_q <= 1'b0;
         cy_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_wr_q <= wb_wr_d;
         wb_reg_q <= wb_reg_d;
         wb_data_q <= wb_data_d;
         flag_cmp_q <= flag_cmp_d;
         cy_q <= cy_d;
         ov_q <= ov_d;
      end
   assign bus.o_unique_ack = ack;
   assign bus.o_sela = bus.i_rega;
   assign bus.o_selb = bus.i_regb;
   assign bus.o_write_reg = wb_reg_q;
   assign bus.o_write_data = wb_data_q;
   assign bus.o_write_en = wb_valid_q & wb_wr_q & !bus.i_stall;
   assign bus.o_write_flag = wb_valid_q & !wb_wr_q & !bus.i_stall;
   assign bus.o_flag_cmp = flag_cmp_q;
   assign bus.o_flag_cy = cy_q;
   assign bus.o_flag_ov = ov_q;
   assign bus.o_busy = s1_busy | wb_valid_q;
   assign bus.o_busy_reg = s1_wr ? s1_regd : (wb_valid_q & wb_wr_q) ? wb_reg_q : 5'd0;
endmodule

// File: tb/tb_pu_add_cmp_pipe.sv
// tb_pu_add_cmp_pipe: directed self-checking bench for the 2-stage add/compare unit.
module tb_pu_add_cmp_pipe;
   localparam logic [5:0] SUB = 6'b000001, ADD = 6'b000010, ICMP = 6'b000011;
   localparam logic [5:0] ADDI = 6'b000100, ICMPI = 6'b000101, ADDC = 6'b000110;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
`ifdef PU_ADD_CMP_SATURATE_EN
   localparam logic [63:0] ADD_OVF = SMAX;
   localparam logic [63:0] SUB_OVF = SMIN;
`else
   localparam logic [63:0] ADD_OVF = SMIN;
   localparam logic [63:0] SUB_OVF = SMAX;
`endif
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0] cop;
      logic exp;
   } cv_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_pass = 0;
   cv_t cv [27];
   pu_add_cmp_pipe_if #(.REG_W(64), .OPC_W(6), .IMM_W(16)) bus ();
   pu_add_cmp_pipe #(
      .OPTION_REG_WIDTH(64), .OPTION_OPCODE_WIDTH(6), .OPTION_IMM_WIDTH(16), .OPTION_PIPE_STAGES(2)
   ) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.i_valid = 1'b0;
      bus.i_unique_ack = 1'b0;
      bus.i_opcode = '0;
   endtask
   task automatic drive(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [15:0] imm, input logic [3:0] cop, input logic [4:0] rd);
      bus.i_valid = 1'b1;
      bus.i_unique_ack = 1'b0;
      bus.i_opcode = op;
      bus.i_ina = a;
      bus.i_inb = b;
      bus.i_imm = imm;
      bus.i_cmp_op = cop;
      bus.i_regd = rd;
      bus.i_rega = rd + 5'd1;
      bus.i_regb = rd + 5'd2;
   endtask
   task automatic exec_op(input string tag, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [15:0] imm, input logic [3:0] cop, input logic [4:0] rd,
                          input logic [63:0] exp_val, input logic exp_cy, input logic exp_ov);
      int lat;
      logic is_cmp;
      is_cmp = (op == ICMP) || (op == ICMPI);
      drive(op, a, b, imm, cop, rd);
      #1;
      check({tag, " ack"}, bus.o_unique_ack, 1'b1);
      tick();
      idle();
      lat = 0;
      for (int i = 1; i <= 6 && lat == 0; i++) begin
         if (bus.o_write_en | bus.o_write_flag) lat = i;
         else tick();
      end
      check({tag, " latency"}, lat, 2);
      check({tag, " write_en"}, bus.o_write_en, !is_cmp);
      check({tag, " write_flag"}, bus.o_write_flag, is_cmp);
      if (is_cmp) check({tag, " flag_cmp"}, bus.o_flag_cmp, exp_val[0]);
      else begin
         check({tag, " data"}, bus.o_write_data, exp_val);
         check({tag, " reg"}, bus.o_write_reg, rd);
      end
      check({tag, " cy"}, bus.o_flag_cy, exp_cy);
      check({tag, " ov"}, bus.o_flag_ov, exp_ov);
      tick();
      check({tag, " strobe once"}, {bus.o_write_en, bus.o_write_flag}, 2'b00);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
   initial begin
      int seen;
      cv = '{
         '{64'd2, 64'd5, 4'd10, 1'b0}, '{64'd2, 64'd5, 4'd1, 1'b1}, '{64'd2, 64'd5, 4'd2, 1'b0},
         '{64'd2, 64'd5, 4'd3, 1'b0}, '{64'd2, 64'd5, 4'd4, 1'b0}, '{64'd2, 64'd5, 4'd5, 1'b0},
         '{64'd2, 64'd5, 4'd6, 1'b1}, '{64'd2, 64'd5, 4'd7, 1'b1}, '{64'd2, 64'd5, 4'd8, 1'b1},
         '{64'd2, 64'd5, 4'd9, 1'b1}, '{64'd2, 64'd5, 4'd0, 1'b0}, '{64'd2, 64'd5, 4'd15, 1'b0},
         '{ONES, 64'd1, 4'd2, 1'b1}, '{ONES, 64'd1, 4'd3, 1'b0}, '{ONES, 64'd1, 4'd4, 1'b1},
         '{ONES, 64'd1, 4'd5, 1'b0}, '{ONES, 64'd1, 4'd6, 1'b0}, '{ONES, 64'd1, 4'd7, 1'b1},
         '{64'd7, 64'd7, 4'd10, 1'b1}, '{64'd7, 64'd7, 4'd1, 1'b0}, '{64'd7, 64'd7, 4'd2, 1'b0},
         '{64'd7, 64'd7, 4'd3, 1'b0}, '{64'd7, 64'd7, 4'd8, 1'b1}, '{64'd7, 64'd7, 4'd9, 1'b1},
         '{SMIN, 64'd1, 4'd3, 1'b0}, '{SMIN, 64'd1, 4'd7, 1'b1}, '{SMIN, 64'd1, 4'd2, 1'b1}
      };
      bus.i_stall = 1'b0;
      bus.i_rega = '0;
      bus.i_regb = '0;
      bus.i_regd = '0;
      bus.i_imm = '0;
      bus.i_cmp_op = '0;
      bus.i_ina = '0;
      bus.i_inb = '0;
      idle();
      #2;
      check("rst write_en", bus.o_write_en, 1'b0);
      check("rst write_flag", bus.o_write_flag, 1'b0);
      check("rst write_data", bus.o_write_data, 64'd0);
      check("rst write_reg", bus.o_write_reg, 5'd0);
      check("rst flag_cmp", bus.o_flag_cmp, 1'b0);
      check("rst cy", bus.o_flag_cy, 1'b0);
      check("rst ov", bus.o_flag_ov, 1'b0);
      check("rst busy", bus.o_busy, 1'b0);
      check("rst busy_reg", bus.o_busy_reg, 5'd0);
      @(negedge clk) rst = 1'b0;
      tick();
      exec_op("add_wrap", ADD, ONES, 64'd1, 16'h0, 4'd0, 5'd3, 64'd0, 1'b1, 1'b0);
      exec_op("add_ovf", ADD, SMAX, 64'd1, 16'h0, 4'd0, 5'd4, ADD_OVF, 1'b0, 1'b1);
      exec_op("icmpi_gts", ICMPI, 64'hFFFF_FFFF_FFFF_FFFB, 64'hDEAD, 16'h0003, 4'd3, 5'd9, 64'd0, 1'b0, 1'b1);
      exec_op("icmpi_gtu", ICMPI, 64'hFFFF_FFFF_FFFF_FFFB, 64'hDEAD, 16'h0003, 4'd2, 5'd9, 64'd1, 1'b0, 1'b1);
      exec_op("sub_borrow", SUB, 64'd3, 64'd5, 16'h0, 4'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
      exec_op("sub_plain", SUB, 64'd5, 64'd3, 16'h0, 4'd0, 5'd7, 64'd2, 1'b0, 1'b0);
      exec_op("sub_ovf", SUB, SMIN, 64'd1, 16'h0, 4'd0, 5'd8, SUB_OVF, 1'b0, 1'b1);
      exec_op("addi_neg", ADDI, 64'd10, 64'h1234, 16'hFFFE, 4'd0, 5'd9, 64'd8, 1'b1, 1'b0);
      exec_op("addc_cyreg", ADDC, 64'd5, 64'd6, 16'h0, 4'd0, 5'd10, 64'd12, 1'b0, 1'b0);
      exec_op("add_setcy", ADD, ONES, 64'd1, 16'h0, 4'd0, 5'd3, 64'd0, 1'b1, 1'b0);
      exec_op("addc_nosat", ADDC, SMAX, 64'd0, 16'h0, 4'd0, 5'd11, SMIN, 1'b0, 1'b1);
      for (int k = 0; k < 27; k++)
         exec_op($sformatf("cmp%0d", k), ICMP, cv[k].a, cv[k].b, 16'h0, cv[k].cop, 5'd10,
                 {63'd0, cv[k].exp}, 1'b0, 1'b1);
      drive(ADD, 64'd1, ONES, 16'h0, 4'd0, 5'd11);
      #1;
      check("b2b ack0", bus.o_unique_ack, 1'b1);
      check("b2b sela", bus.o_sela, 5'd12);
      check("b2b selb", bus.o_selb, 5'd13);
      tick();
      drive(ADDC, 64'd0, 64'd0, 16'h0, 4'd0, 5'd12);
      #1;
      check("b2b ack1", bus.o_unique_ack, 1'b1);
      tick();
      idle();
      check("b2b wen0", bus.o_write_en, 1'b1);
      check("b2b data0", bus.o_write_data, 64'd0);
      check("b2b reg0", bus.o_write_reg, 5'd11);
      check("b2b busy", bus.o_busy, 1'b1);
      check("b2b busy_reg", bus.o_busy_reg, 5'd12);
      tick();
      check("b2b wen1", bus.o_write_en, 1'b1);
      check("b2b data1", bus.o_write_data, 64'd1);
      check("b2b reg1", bus.o_write_reg, 5'd12);
      check("b2b cy", bus.o_flag_cy, 1'b0);
      tick();
      check("b2b idle wen", bus.o_write_en, 1'b0);
      check("b2b idle busy", bus.o_busy, 1'b0);
      drive(ADD, 64'd1, 64'd1, 16'h0, 4'd0, 5'd4);
      tick();
      drive(ADD, 64'd2, 64'd2, 16'h0, 4'd0, 5'd5);
      tick();
      bus.i_stall = 1'b1;
      drive(ADD, 64'd9, 64'd9, 16'h0, 4'd0, 5'd6);
      #1;
      check("stall ack", bus.o_unique_ack, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("stall%0d wen", i), bus.o_write_en, 1'b0);
         check($sformatf("stall%0d wflag", i), bus.o_write_flag, 1'b0);
         check($sformatf("stall%0d data", i), bus.o_write_data, 64'd2);
         check($sformatf("stall%0d busy", i), bus.o_busy, 1'b1);
         tick();
      end
      bus.i_stall = 1'b0;
      #1;
      check("release wen0", bus.o_write_en, 1'b1);
      check("release data0", bus.o_write_data, 64'd2);
      check("release reg0", bus.o_write_reg, 5'd4);
      tick();
      check("release wen1", bus.o_write_en, 1'b1);
      check("release data1", bus.o_write_data, 64'd4);
      check("release reg1", bus.o_write_reg, 5'd5);
      tick();
      check("release done", bus.o_write_en, 1'b0);
      drive(ADD, 64'd1, 64'd1, 16'h0, 4'd0, 5'd13);
      bus.i_unique_ack = 1'b1;
      #1;
      check("uack blocked", bus.o_unique_ack, 1'b0);
      tick();
      idle();
      check("uack no busy", bus.o_busy, 1'b0);
      drive(6'b000111, 64'd1, 64'd1, 16'h0, 4'd0, 5'd13);
      #1;
      check("bad op 7", bus.o_unique_ack, 1'b0);
      drive(6'b000000, 64'd1, 64'd1, 16'h0, 4'd0, 5'd13);
      #1;
      check("bad op 0", bus.o_unique_ack, 1'b0);
      drive(6'b100010, 64'd1, 64'd1, 16'h0, 4'd0, 5'd13);
      #1;
      check("bad op hi", bus.o_unique_ack, 1'b0);
      idle();
      tick();
      check("bad op no busy", bus.o_busy, 1'b0);
      exec_op("pre_rst", ADD, ONES, ONES, 16'h0, 4'd0, 5'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
      drive(ADD, 64'd1, 64'd2, 16'h0, 4'd0, 5'd15);
      tick();
      idle();
      check("mid busy", bus.o_busy, 1'b1);
      check("mid busy_reg", bus.o_busy_reg, 5'd15);
      #2 rst = 1'b1;
      #1;
      check("arst busy", bus.o_busy, 1'b0);
      check("arst busy_reg", bus.o_busy_reg, 5'd0);
      check("arst data", bus.o_write_data, 64'd0);
      check("arst reg", bus.o_write_reg, 5'd0);
      check("arst cy", bus.o_flag_cy, 1'b0);
      check("arst flag_cmp", bus.o_flag_cmp, 1'b0);
      check("arst wen", bus.o_write_en, 1'b0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (4) begin
         tick();
         seen += int'(bus.o_write_en | bus.o_write_flag);
      end
      check("arst no writeback", seen, 0);
      exec_op("post_rst", ADD, 64'd2, 64'd3, 16'h0, 4'd0, 5'd1, 64'd5, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pu_add_cmp_pipe.md
Name: pu_add_cmp_pipe

Overview:
Pipelined, parametrised successor of the single-cycle add/compare processing unit. It sits in the processing-unit ack chain, executes ADD/SUB/ADDI/ADDC/ICMP/ICMPI, and keeps architectural carry (CY) and overflow (OV) flags. The compare flag is driven for all ten compare conditions. Results and flags are registered with configurable latency and global stall.

Parameters:
OPTION_REG_WIDTH, 64, datapath and register width.
OPTION_OPCODE_WIDTH, 6, opcode width.
OPTION_IMM_WIDTH, 16, immediate width; sign-extended to OPTION_REG_WIDTH.
OPTION_PIPE_STAGES, 2, issue-to-writeback latency; legal values 1 or 2.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  control unit presents an operation this cycle
i_stall  in  1  global stall; freezes every pipeline stage
i_opcode  in  OPTION_OPCODE_WIDTH  operation
i_rega, i_regb, i_regd  in  5  source A, source B and destination register numbers
i_imm  in  OPTION_IMM_WIDTH  immediate for ADDI/ICMPI
i_cmp_op  in  4  compare condition index
i_unique_ack  in  1  upstream unit already claims the operation
o_unique_ack  out  1  this unit claims the operation (combinational)
o_sela, o_selb  out  5  register read selects (combinational = i_rega, i_regb)
i_ina, i_inb  in  OPTION_REG_WIDTH  register read data
o_write_reg  out  5  writeback register number
o_write_data  out  OPTION_REG_WIDTH  writeback data
o_write_en  out  1  one-cycle writeback strobe
o_flag_cmp  out  1  compare result
o_write_flag  out  1  one-cycle compare-flag write strobe
o_flag_cy, o_flag_ov  out  1  architectural carry and overflow flags
o_busy  out  1  some pipeline stage holds a valid operation
o_busy_reg  out  5  i_regd of the youngest in-flight register-writing operation

Behaviour:
- Opcodes:
  - SUB=000001, ADD=000010, ICMP=000011, ADDI=000100, ICMPI=000101, ADDC=000110.
  - The immediate replaces B for ADDI and ICMPI.
- Issue: o_unique_ack = i_valid & !i_stall & !i_unique_ack & opcode match. Operands, opcode, regd, imm and cmp_op are captured on an ack edge.
- Latency:
  - OPTION_PIPE_STAGES=1: result and flags registered on the issue edge; strobes high in the following cycle.
  - OPTION_PIPE_STAGES=2: stage 1 registers operands; stage 2 computes and registers results; strobes appear 2 cycles after issue.
  - Back-to-back issue gives 1 op/cycle throughput.
- Stall: while i_stall=1, no stage advances and the strobes are held low. Outputs are retained, and a held op re-asserts its strobe once on release.
- Arithmetic:
  - {c,sum} = A + B' + cin.
  - ADD/ADDI: B'=B, cin=0. SUB/ICMP/ICMPI: B'=~B, cin=1. ADDC: B'=B, cin=CY.
  - ov = (A[msb]==B'[msb]) & (A[msb]^sum[msb]).
- Flag updates:
  - CY and OV update only on the writeback of ADD/SUB/ADDI/ADDC.
  - For SUB, CY = borrow = !c.
  - Compares do not alter CY/OV.
- ADDC carry-in: uses the CY produced by the nearest older flag-writing op still in flight (forwarded). Otherwise it uses the CY register.
- Compare conditions:
  - eq = (A==B); ltu = !c; lts = sum[msb]^ov.
  - Index → condition: EQ=10, NEQ=1, GTU=2, GTS=3, GEU=4, GES=5, LTU=6, LTS=7, LEU=8, LES=9.
  - Any other index gives o_flag_cmp=0 with o_write_flag still pulsed.
- Writeback gating:
  - o_write_en is asserted for ADD/SUB/ADDI/ADDC.
  - o_write_flag is asserted for ICMP/ICMPI.
  - Only one of the two is ever high per op.
- Hazards: no register-data forwarding. The control unit interlocks using o_busy/o_busy_reg.
- Reset (async, any time, including mid-pipeline):
  - All stage valid bits, strobes, o_write_data, o_write_reg, o_flag_cmp, CY, OV and o_busy_reg clear to 0.
  - In-flight ops are discarded.
  - The first issue is possible the cycle after i_rst deasserts.
- i_unique_ack=1 with a matching opcode: no ack, no state change.

Optional Feature:
- PU_ADD_CMP_SATURATE_EN.
- Defined: ADD/SUB/ADDI with signed overflow write the signed saturation value instead of the wrapped sum. That value is 0x7FF..F when A[msb]=0, else 0x800..0. OV is still set.
- Undefined: the wrapped sum is written.
- ADDC never saturates.

Decomposition:
- Shared package pu_pkg: opcode constants, FLAG_INDEX_* constants, and a pipeline-stage struct typedef (valid, opcode, regd, cmp_op, A, B).
- One sub-module, pu_addsub_core: combinational adder producing sum, c, ov and the flag decode.
- The pipeline, forwarding and saturation logic live in the top module.

Test Plan:
- ADD r3=r1+r2 with 0xFFFF_FFFF_FFFF_FFFF + 1, PIPE=2 → o_write_en exactly 2 cycles after ack, data 0, CY=1, OV=0.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → data 0x8000_0000_0000_0000, OV=1. With PU_ADD_CMP_SATURATE_EN defined → data 0x7FFF_FFFF_FFFF_FFFF.
- ICMPI A=-5, imm=16'h0003, cmp_op=3 (GTS) → 0. Same with cmp_op=2 (GTU) → 1. CY/OV unchanged.
- Back-to-back ADD (1+0xFFFF..F) then ADDC (0+0) → second writeback = 1 (forwarded CY), one op per cycle.
- i_stall high for 3 cycles with 2 ops in flight → no strobes during the stall. Strobes resume in order after release, each pulsed once.
- Assert i_rst mid-pipeline with an op in stage 1 → all outputs 0 asynchronously, no writeback after release. i_unique_ack=1 → o_unique_ack=0.
